cpu_controller: RTL
===================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; every state and output change occurs on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have the port instr, input, 16 bits: the latched instruction; opcode = [15:12], cond/dest = [11:8], ext = [7:4].
REQ-004 The module SHALL have the port aluOutIsZero, input, 1 bit: zero flag of the current ALU result; it is unused by this block and reserved.
REQ-005 The module SHALL have the port PSR, input, 8 bits: condition flags, with C=[0], L=[2], F=[5], Z=[6], N=[7].
REQ-006 The module SHALL have the outputs pcEn, instrWrite, regWrite, writeBackSelect, dataToWriteSelect, newAluInput and memWrite, each 1 bit, active-high.
REQ-007 The module SHALL have the outputs aluSrc1Select, aluSrc2Select and pcSrc, each 2 bits.
REQ-008 The module SHALL have the output state, 4 bits, exposing the current FSM state encoding for debug.

Function
REQ-009 All outputs SHALL be Moore outputs decoded from the state register only, and every output not listed for a state SHALL be 0.
REQ-010 Each state and its asserted outputs SHALL be:
- F0: PC settles into the memory address register; no outputs asserted.
- F1: memory read in progress; no outputs asserted.
- F2: instrWrite=1, pcEn=1, pcSrc=00 (PC+1).
- DEC: newAluInput=1.
- EX: writeBackSelect=0; aluSrc1Select=01; aluSrc2Select=00 for R-type, 01 for immediate.
- WB: regWrite=1, writeBackSelect=0; the aluSrc selects are held from EX.
- LD0 and LD1: no outputs asserted.
- LD2: writeBackSelect=1.
- LD3: writeBackSelect=1, regWrite=1.
- ST: memWrite=1.
- JMP: pcEn=1, pcSrc=01.
- JAL: pcEn=1, pcSrc=01, regWrite=1, dataToWriteSelect=1.
- BR: pcEn=1, pcSrc=10.
REQ-011 Instructions SHALL be decoded in DEC as follows:
- opcode 0000: R-type ALU.
- opcodes 0001, 0011, 0101, 1001, 1011, 1101: immediate ALU.
- opcode 0100 with ext 0000: LOAD.
- opcode 0100 with ext 0100: STOR.
- opcode 0100 with ext 1000: JAL.
- opcode 0100 with ext 1100: Jcond.
- opcode 1100: Bcond.
- Anything else is illegal.
REQ-012 The state transitions SHALL be:
- F0 -> F1 -> F2 -> DEC.
- DEC -> EX for an ALU instruction.
- DEC -> LD0 for LOAD; LD0 -> LD1 -> LD2 -> LD3 -> F0.
- DEC -> ST -> F0 for STOR.
- DEC -> JAL -> F0.
- DEC -> JMP for Jcond whose condition is true, else DEC -> F0.
- DEC -> BR for Bcond whose condition is true, else DEC -> F0.
- JMP -> F0 and BR -> F0.
- DEC -> F0 for an illegal instruction, with no side effects.
REQ-013 EX SHALL go to WB, except for compare instructions (opcode 0000 with ext 1011, or opcode 1011), which SHALL go from EX to F0 with no register write.
REQ-014 WB SHALL go to F0.
REQ-015 The condition instr[11:8] SHALL be evaluated as:
- 0000 EQ: Z=1.
- 0001 NE: Z=0.
- 0010 CS: C=1.
- 0011 CC: C=0.
- 0110 GT: N=1.
- 0111 LE: N=0.
- 1110 UC: always true.
- Any other code: never true.
REQ-016 The condition SHALL be evaluated from PSR as sampled in DEC.
REQ-017 Instruction latency SHALL be, counted from F0 entry to the next F0 entry: ALU 6 cycles, compare 5, LOAD 8, STOR 5, JAL 5, taken branch or jump 5, not-taken branch or jump 4, illegal 4.
REQ-018 The controller SHALL never assert pcEn in two consecutive cycles.
REQ-019 The controller SHALL never assert regWrite and memWrite in the same cycle.
REQ-020 The state encodings SHALL be F0=0, F1=1, F2=2, DEC=3, EX=4, WB=5, LD0=6, LD1=7, LD2=8, LD3=9, ST=10, JMP=11, JAL=12, BR=13; the codes 14 and 15 are unused and SHALL transition to F0 on the next edge.

Reset
REQ-021 When reset is asserted, the FSM SHALL go to F0 immediately, without waiting for a clock edge, and all outputs SHALL be 0, with state=0.
REQ-022 A reset asserted mid-instruction SHALL abort that instruction; a partially completed LOAD or STOR SHALL produce no write.
REQ-023 Execution SHALL restart at F0 on the first rising clock edge after reset deasserts.

Verification
REQ-024 The bench SHALL cover ALU: reset, then instr=0x0512 (ADD r5,r2) -> state sequence 0,1,2,3,4,5,0; regWrite=1 only in cycle 6.
REQ-025 The bench SHALL cover CMP: instr=0x03B4 -> EX then F0, with regWrite never asserted over its 5 cycles.
REQ-026 The bench SHALL cover LOAD: instr=0x4203 -> states 6,7,8,9; writeBackSelect=1 in LD2 and LD3; regWrite=1 only in LD3; 8 cycles total.
REQ-027 The bench SHALL cover Bcond: instr=0xC0F0 with PSR[6]=1 -> BR state with pcEn=1 and pcSrc=10; the same instruction with PSR[6]=0 -> DEC then F0, with pcEn not asserted after F2.
REQ-028 The bench SHALL cover JAL: instr=0x4E84 -> JAL state with regWrite=1, dataToWriteSelect=1, pcSrc=01 and pcEn=1 all in the same cycle.
REQ-029 The bench SHALL cover reset during LD1: assert reset mid-cycle -> state=0 and all outputs 0 before the next clock edge, with regWrite never asserted.

Source files
------------

// File: rtl/cpu_controller.sv
// Multi-cycle instruction sequencer: fetch, decode and per-class execute states.
// All control outputs are Moore outputs of the state register (plus two instruction-class flags latched in DEC).
//
// state | meaning
// F0    | PC drives memory address register
// F1    | instruction memory read in progress
// F2    | latch instruction, PC <= PC+1
// DEC   | decode, present operands to ALU
// EX    | ALU executes (R-type or immediate operand)
// WB    | ALU result written to register file
// LD0-3 | load address phase, memory read, write-back select, register write
// ST    | memory write
// JMP   | PC <= jump target
// JAL   | PC <= jump target, link register written
// BR    | PC <= branch target
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        aluOutIsZero,
    input  logic [7:0]  PSR,
    output logic        pcEn,
    output logic        instrWrite,
    output logic        regWrite,
    output logic        writeBackSelect,
    output logic        dataToWriteSelect,
    output logic        newAluInput,
    output logic        memWrite,
    output logic [1:0]  aluSrc1Select,
    output logic [1:0]  aluSrc2Select,
    output logic [1:0]  pcSrc,
    output logic [3:0]  state
);

    localparam logic [3:0] S_F0  = 4'd0;
    localparam logic [3:0] S_F1  = 4'd1;
    localparam logic [3:0] S_F2  = 4'd2;
    localparam logic [3:0] S_DEC = 4'd3;
    localparam logic [3:0] S_EX  = 4'd4;
    localparam logic [3:0] S_WB  = 4'd5;
    localparam logic [3:0] S_LD0 = 4'd6;
    localparam logic [3:0] S_LD1 = 4'd7;
    localparam logic [3:0] S_LD2 = 4'd8;
    localparam logic [3:0] S_LD3 = 4'd9;
    localparam logic [3:0] S_ST  = 4'd10;
    localparam logic [3:0] S_JMP = 4'd11;
    localparam logic [3:0] S_JAL = 4'd12;
    localparam logic [3:0] S_BR  = 4'd13;

    logic [3:0] curState;
    logic [3:0] nextState;
    logic       immReg;
    logic       cmpReg;

    logic [3:0] opcode;
    logic [3:0] cond;
    logic [3:0] ext;
    logic       isRType;
    logic       isImm;
    logic       isAlu;
    logic       isCompare;
    logic       isLoad;
    logic       isStore;
    logic       isJal;
    logic       isJcond;
    logic       isBcond;
    logic       condTrue;

    // Zero flag, unused PSR flags and the low instruction nibble are not needed here.
    logic unusedBits;
    assign unusedBits = ^{aluOutIsZero, PSR[5:1], instr[3:0]};

    assign opcode = instr[15:12];
    assign cond   = instr[11:8];
    assign ext    = instr[7:4];

    always_comb begin
        isRType   = (opcode == 4'b0000);
        isImm     = (opcode == 4'b0001) || (opcode == 4'b0011) || (opcode == 4'b0101) ||
                    (opcode == 4'b1001) || (opcode == 4'b1011) || (opcode == 4'b1101);
        isAlu     = isRType || isImm;
        isCompare = (isRType && (ext == 4'b1011)) || (opcode == 4'b1011);
        isLoad    = (opcode == 4'b0100) && (ext == 4'b0000);
        isStore   = (opcode == 4'b0100) && (ext == 4'b0100);
        isJal     = (opcode == 4'b0100) && (ext == 4'b1000);
        isJcond   = (opcode == 4'b0100) && (ext == 4'b1100);
        isBcond   = (opcode == 4'b1100);
    end

    // Z=PSR[6], C=PSR[0], N=PSR[7]
    always_comb begin
        case (cond)
            4'b0000: condTrue = PSR[6];
            4'b0001: condTrue = ~PSR[6];
            4'b0010: condTrue = PSR[0];
            4'b0011: condTrue = ~PSR[0];
            4'b0110: condTrue = PSR[7];
            4'b0111: condTrue = ~PSR[7];
            4'b1110: condTrue = 1'b1;
            default: condTrue = 1'b0;
        endcase
    end

    // immReg/cmpReg freeze the ALU class in DEC so EX/WB outputs depend on registers only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState <= S_F0;
            immReg   <= 1'b0;
            cmpReg   <= 1'b0;
        end else begin
            curState <= nextState;
            if (curState == S_DEC) begin
                immReg <= isImm;
                cmpReg <= isCompare;
            end
        end
    end

    always_comb begin
        nextState = S_F0;
        case (curState)
            S_F0:  nextState = S_F1;
            S_F1:  nextState = S_F2;
            S_F2:  nextState = S_DEC;
            S_DEC: begin
                if (isAlu)
                    nextState = S_EX;
                else if (isLoad)
                    nextState = S_LD0;
                else if (isStore)
                    nextState = S_ST;
                else if (isJal)
                    nextState = S_JAL;
                else if (isJcond)
                    nextState = condTrue ? S_JMP : S_F0;
                else if (isBcond)
                    nextState = condTrue ? S_BR : S_F0;
                else
                    nextState = S_F0;
            end
            S_EX:  nextState = cmpReg ? S_F0 : S_WB;
            S_LD0: nextState = S_LD1;
            S_LD1: nextState = S_LD2;
            S_LD2: nextState = S_LD3;
            default: nextState = S_F0;
        endcase
    end

    always_comb begin
        pcEn              = 1'b0;
        instrWrite        = 1'b0;
        regWrite          = 1'b0;
        writeBackSelect   = 1'b0;
        dataToWriteSelect = 1'b0;
        newAluInput       = 1'b0;
        memWrite          = 1'b0;
        aluSrc1Select     = 2'b00;
        aluSrc2Select     = 2'b00;
        pcSrc             = 2'b00;
        case (curState)
            S_F2: begin
                instrWrite = 1'b1;
                pcEn       = 1'b1;
            end
            S_DEC: newAluInput = 1'b1;
            S_EX: begin
                aluSrc1Select = 2'b01;
                aluSrc2Select = immReg ? 2'b01 : 2'b00;
            end
            S_WB: begin
                regWrite      = 1'b1;
                aluSrc1Select = 2'b01;
                aluSrc2Select = immReg ? 2'b01 : 2'b00;
            end
            S_LD2: writeBackSelect = 1'b1;
            S_LD3: begin
                writeBackSelect = 1'b1;
                regWrite        = 1'b1;
            end
            S_ST:  memWrite = 1'b1;
            S_JMP: begin
                pcEn  = 1'b1;
                pcSrc = 2'b01;
            end
            S_JAL: begin
                pcEn              = 1'b1;
                pcSrc             = 2'b01;
                regWrite          = 1'b1;
                dataToWriteSelect = 1'b1;
            end
            S_BR: begin
                pcEn  = 1'b1;
                pcSrc = 2'b10;
            end
            default: ;
        endcase
    end

    assign state = curState;

endmodule
